encoding_block: RTL and testbench

//  Transmit-side symbol encoder of the USB4 logical layer; the inverse of the receive decoder.

---
 rtl/usb4_enc_pkg.sv | 32 +++
 rtl/enc_lane_packer.sv | 66 ++++++
 rtl/encoding_block.sv | 109 ++++++++++
 tb/tb_encoding_block.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb4_enc_pkg.sv
// Shared constants, generation codes and sync headers for the USB4 TX symbol encoder.
// Used by encoding_block and enc_lane_packer.
package usb4_enc_pkg;

  localparam int LANE_W    = 8;
  localparam int SYM_W     = 132;
  localparam int BUF_DEPTH = 16;

  typedef enum logic [1:0] {
    GEN4     = 2'b00,
    GEN3     = 2'b01,
    GEN2     = 2'b10,
    GEN_RSVD = 2'b11
  } gen_e;

  localparam logic [3:0] HDR_GEN3_DATA = 4'b1010;
  localparam logic [3:0] HDR_GEN3_OS   = 4'b0101;
  localparam logic [1:0] HDR_GEN2_DATA = 2'b10;
  localparam logic [1:0] HDR_GEN2_OS   = 2'b01;

  // Index of the last byte in a symbol; the reserved code never completes a symbol.
  function automatic logic [3:0] max_byte(input logic [1:0] gen);
    logic [3:0] mb;
    case (gen)
      GEN4, GEN3: mb = 4'd15;
      GEN2:       mb = 4'd7;
      default:    mb = 4'd0;
    endcase
    return mb;
  endfunction

endpackage

// File: rtl/enc_lane_packer.sv
// One lane's 16-byte collection buffer plus combinational symbol assembly.
// The assembled symbol already includes the byte being written this cycle.
module enc_lane_packer
  import usb4_enc_pkg::*;
(
  input  logic              enc_clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [3:0]        wr_idx,
  input  logic [LANE_W-1:0] wr_byte,
  input  logic [1:0]        gen_speed,
  input  logic              hdr_data,
  output logic [SYM_W-1:0]  sym
);

  logic [LANE_W-1:0] byte_buf  [BUF_DEPTH];
  logic [LANE_W-1:0] byte_view [BUF_DEPTH];

  // NOTE: the buffer is only 16 bytes, so it is cleared on reset like any other
  // register; larger RAM-style arrays would normally be left unreset.
  always_ff @(posedge enc_clk) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        byte_buf[i] <= '0;
      end
    end else if (wr_en) begin
      // NOTE: non-blocking assignment keeps every register update in this block
      // simultaneous, independent of statement order.
      byte_buf[wr_idx] <= wr_byte;
    end
  end

  // Bypass the byte being written so the last byte is in the symbol the same cycle.
  always_comb begin
    for (int i = 0; i < BUF_DEPTH; i++) begin
      byte_view[i] = (wr_en && (wr_idx == 4'(i))) ? wr_byte : byte_buf[i];
    end
  end

  // NOTE: sym gets a full default first so no path through the case leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    sym = '0;
    case (gen_speed)
      GEN4: begin
        for (int k = 0; k < 16; k++) begin
          sym[8*k +: 8] = byte_view[k];
        end
      end
      GEN3: begin
        sym[3:0] = hdr_data ? HDR_GEN3_DATA : HDR_GEN3_OS;
        for (int k = 0; k < 16; k++) begin
          sym[8*k+4 +: 8] = byte_view[k];
        end
      end
      GEN2: begin
        sym[1:0] = hdr_data ? HDR_GEN2_DATA : HDR_GEN2_OS;
        for (int k = 0; k < 8; k++) begin
          sym[8*k+2 +: 8] = byte_view[k];
        end
      end
      default: sym = '0;
    endcase
  end

endmodule

// File: rtl/encoding_block.sv
// USB4 TX symbol encoder: packs one byte per lane per cycle into 132-bit symbols.
// Optional type_err output and check logic are built when ENC_TYPE_CHK_EN is defined.
module encoding_block
  import usb4_enc_pkg::*;
(
  input  logic              enc_clk,
  input  logic              rst,
  input  logic              enable_enc,
  input  logic [1:0]        gen_speed,
  input  logic              data_os,
  input  logic [LANE_W-1:0] lane_0_tx,
  input  logic [LANE_W-1:0] lane_1_tx,
  output logic [SYM_W-1:0]  lane_0_tx_enc,
  output logic [SYM_W-1:0]  lane_1_tx_enc,
`ifdef ENC_TYPE_CHK_EN
  output logic              type_err,
`endif
  output logic              enc_valid
);

  logic [3:0]       byte_cnt;
  logic [1:0]       gen_q;
  logic             hdr_q;
  logic             speed_chg;
  logic [3:0]       cnt_eff;
  logic             accept;
  logic             last_byte;
  logic [SYM_W-1:0] sym_0;
  logic [SYM_W-1:0] sym_1;

  // A speed change restarts the symbol: the current byte is treated as byte 0.
  always_comb begin
    speed_chg = (gen_speed != gen_q);
    cnt_eff   = speed_chg ? 4'd0 : byte_cnt;
    accept    = enable_enc && (gen_speed != GEN_RSVD);
    last_byte = accept && (cnt_eff == max_byte(gen_speed));
  end

  always_ff @(posedge enc_clk) begin
    if (rst) begin
      byte_cnt      <= '0;
      gen_q         <= '0;
      hdr_q         <= 1'b0;
      enc_valid     <= 1'b0;
      lane_0_tx_enc <= '0;
      lane_1_tx_enc <= '0;
    end else begin
      gen_q     <= gen_speed;
      enc_valid <= last_byte;
      if (last_byte) begin
        lane_0_tx_enc <= sym_0;
        lane_1_tx_enc <= sym_1;
      end
      if (!accept || last_byte) begin
        byte_cnt <= '0;
      end else begin
        byte_cnt <= cnt_eff + 4'd1;
      end
      if (accept && (cnt_eff == 4'd0)) begin
        hdr_q <= data_os;
      end
    end
  end

  enc_lane_packer u_lane_0 (
    .enc_clk   (enc_clk),
    .rst       (rst),
    .wr_en     (accept),
    .wr_idx    (cnt_eff),
    .wr_byte   (lane_0_tx),
    .gen_speed (gen_speed),
    .hdr_data  (hdr_q),
    .sym       (sym_0)
  );

  enc_lane_packer u_lane_1 (
    .enc_clk   (enc_clk),
    .rst       (rst),
    .wr_en     (accept),
    .wr_idx    (cnt_eff),
    .wr_byte   (lane_1_tx),
    .gen_speed (gen_speed),
    .hdr_data  (hdr_q),
    .sym       (sym_1)
  );

`ifdef ENC_TYPE_CHK_EN
  logic err_acc;
  logic type_mis;

  // Any byte after byte 0 whose data_os disagrees with the latched header.
  assign type_mis = accept && (cnt_eff != 4'd0) && (data_os != hdr_q);

  always_ff @(posedge enc_clk) begin
    if (rst) begin
      err_acc  <= 1'b0;
      type_err <= 1'b0;
    end else begin
      type_err <= last_byte && (err_acc || type_mis);
      if (accept && (cnt_eff == 4'd0)) begin
        err_acc <= 1'b0;
      end else if (type_mis) begin
        err_acc <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_encoding_block.sv
// Self-checking bench for encoding_block: queue-based symbol model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_encoding_block;

  localparam int W = 132;

  logic          enc_clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable_enc = 1'b0;
  logic [1:0]    gen_speed = 2'b01;
  logic          data_os = 1'b0;
  logic [7:0]    lane_0_tx = '0;
  logic [7:0]    lane_1_tx = '0;
  logic [W-1:0]  lane_0_tx_enc;
  logic [W-1:0]  lane_1_tx_enc;
  logic          enc_valid;
`ifdef ENC_TYPE_CHK_EN
  logic          type_err;
`endif

  int total = 0;
  int bad   = 0;

  encoding_block dut (
    .enc_clk       (enc_clk),
    .rst           (rst),
    .enable_enc    (enable_enc),
    .gen_speed     (gen_speed),
    .data_os       (data_os),
    .lane_0_tx     (lane_0_tx),
    .lane_1_tx     (lane_1_tx),
    .lane_0_tx_enc (lane_0_tx_enc),
    .lane_1_tx_enc (lane_1_tx_enc),
`ifdef ENC_TYPE_CHK_EN
    .type_err      (type_err),
`endif
    .enc_valid     (enc_valid)
  );

  always #5 enc_clk = ~enc_clk;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   m_q0[$];
  logic [7:0]   m_q1[$];
  logic         m_hdr = 1'b0;
  logic         m_bad = 1'b0;
  logic [1:0]   m_prev_gen = 2'b00;
  logic [W-1:0] m_enc0 = '0;
  logic [W-1:0] m_enc1 = '0;
  logic         m_valid = 1'b0;
  logic         m_err = 1'b0;

  function automatic logic [W-1:0] build(input logic [1:0] g, input logic h, input logic [7:0] q[$]);
    logic [W-1:0] s;
    s = '0;
    for (int k = 0; k < q.size(); k++) begin
      case (g)
        2'b00: s[8*k +: 8] = q[k];
        2'b01: s[8*k+4 +: 8] = q[k];
        default: s[8*k+2 +: 8] = q[k];
      endcase
    end
    if (g == 2'b01) s[3:0] = h ? 4'b1010 : 4'b0101;
    if (g == 2'b10) s[1:0] = h ? 2'b10 : 2'b01;
    return s;
  endfunction

  task automatic model_step();
    int len;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (rst) begin
      m_q0.delete();
      m_q1.delete();
      m_enc0 = '0;
      m_enc1 = '0;
    end else begin
      if ((gen_speed != m_prev_gen) || !enable_enc || (gen_speed == 2'b11)) begin
        m_q0.delete();
        m_q1.delete();
      end
      if (enable_enc && (gen_speed != 2'b11)) begin
        if (m_q0.size() == 0) begin
          m_hdr = data_os;
          m_bad = 1'b0;
        end else if (data_os != m_hdr) begin
          m_bad = 1'b1;
        end
        m_q0.push_back(lane_0_tx);
        m_q1.push_back(lane_1_tx);
        len = (gen_speed == 2'b10) ? 8 : 16;
        if (m_q0.size() == len) begin
          m_enc0  = build(gen_speed, m_hdr, m_q0);
          m_enc1  = build(gen_speed, m_hdr, m_q1);
          m_valid = 1'b1;
          m_err   = m_bad;
          m_q0.delete();
          m_q1.delete();
        end
      end
    end
    m_prev_gen = gen_speed;
  endtask

  always @(posedge enc_clk) begin
    model_step();
    #1;
    check("enc_valid", W'(enc_valid), W'(m_valid));
    check("lane_0_tx_enc", lane_0_tx_enc, m_enc0);
    check("lane_1_tx_enc", lane_1_tx_enc, m_enc1);
`ifdef ENC_TYPE_CHK_EN
    check("type_err", W'(type_err), W'(m_err));
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic en, input logic [1:0] g, input logic d,
                       input logic [7:0] b0, input logic [7:0] b1);
    @(negedge enc_clk);
    enable_enc = en;
    gen_speed  = g;
    data_os    = d;
    lane_0_tx  = b0;
    lane_1_tx  = b1;
  endtask

  task automatic settle();
    @(posedge enc_clk);
    #2;
  endtask

  task automatic idle();
    drive(1'b0, gen_speed, 1'b0, 8'h00, 8'h00);
    settle();
  endtask

  initial begin
    logic [63:0] a5_bytes;
    a5_bytes = {8{8'hA5}};

    // Reset state
    drive(1'b1, 2'b01, 1'b1, 8'h11, 8'h22);
    settle();
    settle();
    check("rst_lane0", lane_0_tx_enc, '0);
    check("rst_lane1", lane_1_tx_enc, '0);
    check("rst_valid", W'(enc_valid), '0);
    @(negedge enc_clk);
    rst = 1'b0;
    idle();

    // T1: GEN3 data symbol
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 2'b01, 1'b1, 8'(k), 8'(8'hF0 + k));
      settle();
      if (k < 15) check("t1_no_early_valid", W'(enc_valid), '0);
    end
    check("t1_valid", W'(enc_valid), W'(1'b1));
    check("t1_hdr", W'(lane_0_tx_enc[3:0]), W'(4'b1010));
    check("t1_byte0", W'(lane_0_tx_enc[11:4]), W'(8'h00));
    check("t1_byte15", W'(lane_0_tx_enc[131:124]), W'(8'h0F));
    check("t1_lane1_byte0", W'(lane_1_tx_enc[11:4]), W'(8'hF0));
    idle();
    check("t1_pulse_one_cycle", W'(enc_valid), '0);
    check("t1_hold", W'(lane_0_tx_enc[131:124]), W'(8'h0F));

    // T2: GEN2 ordered set
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 2'b10, 1'b0, 8'hA5, 8'hA5);
      settle();
      if (k < 7) check("t2_no_early_valid", W'(enc_valid), '0);
    end
    check("t2_valid", W'(enc_valid), W'(1'b1));
    check("t2_hdr", W'(lane_0_tx_enc[1:0]), W'(2'b01));
    check("t2_payload", W'(lane_0_tx_enc[65:2]), W'(a5_bytes));
    check("t2_upper_zero", W'(lane_0_tx_enc[131:66]), '0);
    idle();

    // T3: GEN4 continuous 48 bytes
    for (int j = 0; j < 48; j++) begin
      drive(1'b1, 2'b00, 1'b1, 8'(j), 8'(~j));
      settle();
      check("t3_valid_cadence", W'(enc_valid), W'((j % 16) == 15));
      if ((j % 16) == 15) begin
        check("t3_byte0", W'(lane_0_tx_enc[7:0]), W'(8'(j - 15)));
        check("t3_top_zero", W'(lane_0_tx_enc[131:128]), '0);
      end
    end
    idle();

    // T4: flush after 5 GEN3 bytes, then a full symbol
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 2'b01, 1'b0, 8'(8'h40 + k), 8'h00);
      settle();
    end
    for (int k = 0; k < 2; k++) begin
      idle();
      check("t4_flush_no_valid", W'(enc_valid), '0);
    end
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 2'b01, 1'b1, 8'(8'h80 + k), 8'(k));
      settle();
      check("t4_valid", W'(enc_valid), W'(k == 15));
    end
    check("t4_byte0", W'(lane_0_tx_enc[11:4]), W'(8'h80));
    idle();

    // T5: GEN3 -> GEN2 at byte 9
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, 2'b01, 1'b0, 8'(k), 8'(k));
      settle();
      check("t5_gen3_no_valid", W'(enc_valid), '0);
    end
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 2'b10, 1'b1, 8'(8'hC0 + k), 8'(8'h30 + k));
      settle();
      check("t5_gen2_valid", W'(enc_valid), W'(k == 7));
    end
    check("t5_hdr", W'(lane_0_tx_enc[1:0]), W'(2'b10));
    check("t5_byte0", W'(lane_0_tx_enc[9:2]), W'(8'hC0));
    check("t5_lane1_byte7", W'(lane_1_tx_enc[65:58]), W'(8'h37));
    idle();

`ifdef ENC_TYPE_CHK_EN
    // T6: header mismatch at byte 4, then reset mid-symbol
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 2'b01, (k < 4), 8'(k), 8'(k));
      settle();
    end
    check("t6_valid", W'(enc_valid), W'(1'b1));
    check("t6_type_err", W'(type_err), W'(1'b1));
    check("t6_hdr", W'(lane_0_tx_enc[3:0]), W'(4'b1010));
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 2'b01, 1'b1, 8'(k), 8'(k));
      settle();
    end
    @(negedge enc_clk);
    rst = 1'b1;
    settle();
    check("t6_rst_lane0", lane_0_tx_enc, '0);
    check("t6_rst_type_err", W'(type_err), '0);
    @(negedge enc_clk);
    rst = 1'b0;
    idle();
`endif

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [1:0] g;
      logic       d;
      logic       e;
      g = gen_speed;
      d = data_os;
      if ($urandom_range(39) == 0) g = 2'($urandom_range(3));
      if ($urandom_range(7) == 0) d = ~d;
      e = ($urandom_range(9) != 0);
      drive(e, g, d, 8'($urandom), 8'($urandom));
      rst = ($urandom_range(299) == 0);
    end
    @(negedge enc_clk);
    rst = 1'b0;
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
